// File: rtl/ldm_writeback_sequencer_pkg.sv
// Shared definitions for the load-multiple writeback sequencer and its helpers.
// Holds the FSM encoding, transfer constants and a list population counter.
package ldm_writeback_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WRITE,
        S_BASE_WB,
        S_DONE
    } state_t;

    localparam int          WORD_BYTES = 4;
    localparam logic [3:0]  PC_INDEX   = 4'd15;
    localparam logic [15:0] LIST_MASK  = 16'h7FFF;

    function automatic logic [4:0] popcount16(input logic [15:0] value);
        logic [4:0] count;
        count = '0;
        for (int i = 0; i < 16; i++) begin
            count = count + 5'(value[i]);
        end
        return count;
    endfunction

endpackage

// File: rtl/ldm_writeback_sequencer_reg_list_pick.sv
// Lowest-set-bit picker over a 16-bit register list, shared by LDM/STM sequencers.
// index is 0 when the list is empty; callers must qualify it with empty.
module ldm_writeback_sequencer_reg_list_pick (
    input  logic [15:0] list,
    output logic [3:0]  index,
    output logic        empty
);

    always_comb begin
        index = '0;
        // Scan downward so the lowest set bit is the last to assign.
        for (int i = 15; i >= 0; i--) begin
            if (list[i]) begin
                index = 4'(i);
            end
        end
    end

    assign empty = (list == 16'h0000);

endmodule

// File: rtl/ldm_writeback_sequencer.sv
// LDM transfer engine: reads one word per listed register and writes each into the
// register file, optionally followed by the updated base address.
module ldm_writeback_sequencer
    import ldm_writeback_sequencer_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32,
    parameter int NUM_REGS = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [15:0]         reg_list,
    input  logic [ADDR_LEN-1:0] base_addr,
    input  logic                incr,
    input  logic                wb_base,
    input  logic [3:0]          base_reg,
    output logic                mem_rd_req,
    output logic [ADDR_LEN-1:0] mem_addr,
    input  logic                mem_rd_ack,
    input  logic [DATA_LEN-1:0] mem_rd_data,
    output logic [DATA_LEN-1:0] Result_WB,
    output logic [3:0]          Dest_wb,
    output logic                writeBackEn,
    output logic                busy,
    output logic                done
);

    localparam logic [15:0] WRITABLE = 16'((32'h1 << NUM_REGS) - 1);

    state_t              state_reg;
    logic [15:0]         list_reg;
    logic [ADDR_LEN-1:0] final_addr_reg;
    logic [3:0]          base_idx_reg;
    logic                base_wb_en_reg;

    logic [15:0]         start_list;
    logic [ADDR_LEN-1:0] span;
    logic [15:0]         pick_list;
    logic [3:0]          pick_index;
    logic                pick_empty;
    logic [15:0]         rest_list;

    assign start_list = reg_list & LIST_MASK & WRITABLE;
    assign span       = ADDR_LEN'(popcount16(start_list)) * ADDR_LEN'(WORD_BYTES);
    // In IDLE the picker judges the incoming list; afterwards it tracks the latched one.
    assign pick_list  = (state_reg == S_IDLE) ? start_list : list_reg;
    assign rest_list  = list_reg & (list_reg - 16'd1);

    ldm_writeback_sequencer_reg_list_pick u_pick (
        .list  (pick_list),
        .index (pick_index),
        .empty (pick_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            list_reg       <= '0;
            final_addr_reg <= '0;
            base_idx_reg   <= '0;
            base_wb_en_reg <= 1'b0;
            mem_rd_req     <= 1'b0;
            mem_addr       <= '0;
            Result_WB      <= '0;
            Dest_wb        <= '0;
            writeBackEn    <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        list_reg       <= start_list;
                        final_addr_reg <= incr ? base_addr + span : base_addr - span;
                        // Both modes walk upward from the lowest address of the block.
                        mem_addr       <= incr ? base_addr : base_addr - span;
                        base_idx_reg   <= base_reg;
                        // A loaded base register wins over the address update.
                        base_wb_en_reg <= wb_base && (base_reg != PC_INDEX) && !start_list[base_reg];
                        busy           <= 1'b1;
                        if (pick_empty) begin
                            done      <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            mem_rd_req <= 1'b1;
                            state_reg  <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_rd_ack) begin
                        mem_rd_req  <= 1'b0;
                        writeBackEn <= 1'b1;
                        Dest_wb     <= pick_index;
                        Result_WB   <= mem_rd_data;
                        state_reg   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    writeBackEn <= 1'b0;
                    list_reg    <= rest_list;
                    mem_addr    <= mem_addr + ADDR_LEN'(WORD_BYTES);
                    if (rest_list != 16'h0000) begin
                        mem_rd_req <= 1'b1;
                        state_reg  <= S_REQ;
                    end else if (base_wb_en_reg) begin
                        writeBackEn <= 1'b1;
                        Dest_wb     <= base_idx_reg;
                        Result_WB   <= DATA_LEN'(final_addr_reg);
                        state_reg   <= S_BASE_WB;
                    end else begin
                        done      <= 1'b1;
                        state_reg <= S_DONE;
                    end
                end
                S_BASE_WB: begin
                    writeBackEn <= 1'b0;
                    done        <= 1'b1;
                    state_reg   <= S_DONE;
                end
                S_DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ldm_writeback_sequencer.sv
// Bench for the LDM writeback sequencer: directed and random transfers against a
// list-walking model of expected register writes, timing and base update.
module tb_ldm_writeback_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] reg_list;
    logic [31:0] base_addr;
    logic        incr;
    logic        wb_base;
    logic [3:0]  base_reg;
    logic        mem_rd_req;
    logic [31:0] mem_addr;
    logic        mem_rd_ack;
    logic [31:0] mem_rd_data;
    logic [31:0] Result_WB;
    logic [3:0]  Dest_wb;
    logic        writeBackEn;
    logic        busy;
    logic        done;

    ldm_writeback_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .reg_list    (reg_list),
        .base_addr   (base_addr),
        .incr        (incr),
        .wb_base     (wb_base),
        .base_reg    (base_reg),
        .mem_rd_req  (mem_rd_req),
        .mem_addr    (mem_addr),
        .mem_rd_ack  (mem_rd_ack),
        .mem_rd_data (mem_rd_data),
        .Result_WB   (Result_WB),
        .Dest_wb     (Dest_wb),
        .writeBackEn (writeBackEn),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic [31:0] data_off = '0;

    // Memory: word at address a reads as a + data_off, acked after ack_delay wait cycles.
    assign mem_rd_ack  = mem_rd_req && (wait_cnt >= ack_delay);
    assign mem_rd_data = mem_addr + data_off;

    always @(posedge clk or posedge rst) begin
        if (rst) wait_cnt <= 0;
        else if (mem_rd_req && !mem_rd_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Register-file side observer, sampling at the falling edge like the register file.
    logic [35:0] wr_q[$];
    int          wr_cyc_q[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          req_cnt = 0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [31:0] prev_addr = '0;

    always @(negedge clk) begin
        if (writeBackEn) begin
            wr_q.push_back({Dest_wb, Result_WB});
            wr_cyc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (mem_rd_req) req_cnt++;
        if (writeBackEn && mem_rd_req) check("wb_req_overlap", 1, 0);
        if (prev_req && mem_rd_req && !prev_ack) check("addr_stable", mem_addr, prev_addr);
        prev_req  = mem_rd_req;
        prev_ack  = mem_rd_ack;
        prev_addr = mem_addr;
    end

    task automatic run_txn(input logic [15:0] list, input logic [31:0] base, input bit inc,
                           input bit wb, input logic [3:0] br, input int dly,
                           input logic [31:0] off, input bit inject, input string name);
        logic [35:0] exp_q[$];
        int          exp_cyc_q[$];
        logic [15:0] m;
        logic [31:0] span;
        logic [31:0] lo;
        int          n;
        int          k;
        int          t;
        int          start_cyc;
        int          exp_done;
        bit          bwb;
        // Model: ascending registers take ascending words from the block's low address.
        m    = list & 16'h7FFF;
        n    = $countones(m);
        span = 32'(4 * n);
        lo   = inc ? base : base - span;
        k    = 0;
        for (int i = 0; i < 15; i++) begin
            if (m[i]) begin
                exp_q.push_back({4'(i), lo + 32'(4 * k) + off});
                exp_cyc_q.push_back((k + 1) * (dly + 2));
                k++;
            end
        end
        bwb = (n > 0) && wb && (br != 4'd15) && !m[br];
        if (bwb) begin
            exp_q.push_back({br, inc ? base + span : base - span});
            exp_cyc_q.push_back(n * (dly + 2) + 1);
        end
        exp_done = (n == 0) ? 1 : n * (dly + 2) + 1 + (bwb ? 1 : 0);

        wr_q.delete();
        wr_cyc_q.delete();
        done_cnt  = 0;
        ack_delay = dly;
        data_off  = off;
        reg_list  = list;
        base_addr = base;
        incr      = inc;
        wb_base   = wb;
        base_reg  = br;
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk); #1;
        start     = 1'b0;
        reg_list  = 16'($urandom);
        base_addr = $urandom;
        incr      = 1'($urandom);
        wb_base   = 1'($urandom);
        base_reg  = 4'($urandom);
        t = 1;
        while (done_cnt == 0 && t < 2000) begin
            start = (inject && (t == 2 || t == 5)) ? 1'b1 : 1'b0;
            @(negedge clk); #1;
            t++;
        end
        start = 1'b0;
        check({name, ".done_seen"}, done_cnt, 1);
        check({name, ".done_cycle"}, done_cyc - start_cyc, exp_done);
        @(negedge clk); #1;
        check({name, ".busy_after"}, busy, 0);
        check({name, ".done_pulse"}, done, 0);
        @(negedge clk); #1;
        check({name, ".done_count"}, done_cnt, 1);
        check({name, ".idle_busy"}, busy, 0);
        check({name, ".write_count"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            check({name, ".write_idx_data"}, wr_q[i], exp_q[i]);
            check({name, ".write_cycle"}, wr_cyc_q[i] - start_cyc, exp_cyc_q[i]);
        end
        $display("txn %s list=%h base=%h incr=%0d wb=%0d br=%0d dly=%0d writes=%0d done_cycle=%0d",
                 name, list, base, inc, wb, br, dly, wr_q.size(), done_cyc - start_cyc);
    endtask

    initial begin
        int t;
        int req_at_release;
        rst       = 1'b1;
        start     = 1'b0;
        reg_list  = '0;
        base_addr = '0;
        incr      = 1'b0;
        wb_base   = 1'b0;
        base_reg  = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", {mem_rd_req, writeBackEn, busy, done, mem_addr, Result_WB, Dest_wb}, 0);
        rst = 1'b0;
        @(negedge clk); #1;
        check("idle_busy", busy, 0);

        run_txn(16'h0015, 32'h0000_0100, 1, 0, 4'd0,  0, 32'h0A0, 0, "ia_three");
        run_txn(16'h0006, 32'h0000_0200, 0, 1, 4'd13, 0, 32'h000, 0, "db_base_wb");
        run_txn(16'h000B, 32'h0000_0400, 1, 1, 4'd3,  0, 32'h055, 0, "base_in_list");
        run_txn(16'h8000, 32'h0000_0500, 1, 1, 4'd2,  0, 32'h000, 0, "pc_only");
        run_txn(16'h0C31, 32'h0000_0800, 1, 1, 4'd9,  3, 32'h321, 1, "slow_ack");
        run_txn(16'h0003, 32'h0000_0900, 1, 1, 4'd15, 0, 32'h000, 0, "base_pc");
        run_txn(16'h800F, 32'hFFFF_FFF8, 1, 1, 4'd7,  1, 32'h111, 0, "wrap_ia");
        run_txn(16'h7FFF, 32'h0000_0010, 0, 1, 4'd0,  0, 32'h777, 0, "all_db");
        for (int r = 0; r < 20; r++) begin
            run_txn(16'($urandom), $urandom, 1'($urandom), 1'($urandom), 4'($urandom),
                    int'($urandom_range(0, 2)), $urandom, 0, "rand");
        end

        // Abort while the second of three words is outstanding.
        wr_q.delete();
        done_cnt  = 0;
        ack_delay = 3;
        data_off  = 32'h40;
        reg_list  = 16'h0007;
        base_addr = 32'h0000_0A00;
        incr      = 1'b1;
        wb_base   = 1'b1;
        base_reg  = 4'd12;
        start     = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        t = 0;
        while (!(wr_q.size() == 1 && mem_rd_req) && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        check("rst_reach_word2", t < 200, 1);
        rst = 1'b1;
        #1;
        check("rst_async_outputs", {mem_rd_req, writeBackEn, busy, done, mem_addr, Result_WB, Dest_wb}, 0);
        @(negedge clk); #1;
        rst = 1'b0;
        req_at_release = req_cnt;
        repeat (8) @(negedge clk);
        #1;
        check("rst_no_more_writes", wr_q.size(), 1);
        check("rst_no_more_reqs", req_cnt, req_at_release);
        check("rst_no_done", done_cnt, 0);
        check("rst_idle", busy, 0);
        $display("txn reset_abort writes=%0d", wr_q.size());

        run_txn(16'h0021, 32'h0000_0C00, 0, 1, 4'd1, 0, 32'h9, 0, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
